// File: rtl/mem_port_arb_if.sv
// Handshake bundle between the fetch/data requesters, the unified memory port and the arbiter.
// The master modport is the arbiter's view; slave is the environment around it.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                ftch_req_vld;
  logic [ADDR_W-1:0]   ftch_req_addr;
  logic                ftch_req_rdy;
  logic                ftch_flush;
  logic                ftch_rsp_vld;
  logic [DATA_W-1:0]   ftch_rsp_data;

  logic                dmem_req_vld;
  logic                dmem_req_we;
  logic [ADDR_W-1:0]   dmem_req_addr;
  logic [DATA_W-1:0]   dmem_req_wdata;
  logic [DATA_W/8-1:0] dmem_req_be;
  logic                dmem_req_rdy;
  logic                dmem_rsp_vld;
  logic [DATA_W-1:0]   dmem_rsp_data;

  logic                mem_req_vld;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_be;
  logic                mem_req_rdy;
  logic                mem_rsp_vld;
  logic [DATA_W-1:0]   mem_rsp_data;

  logic                err;

  modport master (
    input  ftch_req_vld, ftch_req_addr, ftch_flush,
    input  dmem_req_vld, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output ftch_req_rdy, ftch_rsp_vld, ftch_rsp_data,
    output dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data,
    output mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output err
  );

  modport slave (
    output ftch_req_vld, ftch_req_addr, ftch_flush,
    output dmem_req_vld, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  ftch_req_rdy, ftch_rsp_vld, ftch_rsp_data,
    input  dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data,
    input  mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  err
  );
endinterface

// File: rtl/mem_port_arb.sv
// Unified memory port arbiter: data-priority grant with a fetch anti-starvation credit,
// in-order read tag FIFO for response routing, and fetch-response kill on redirect.
module mem_port_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_arb_if.master bus
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [MAX_OUTST-1:0] tag_ftch;
  logic [MAX_OUTST-1:0] tag_kill;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic [SW-1:0]        credit;

  logic                 full;
  logic                 empty;
  logic                 f_elig;
  logic                 d_elig;
  logic                 pick_d;
  logic                 pick_f;
  logic                 xfer;
  logic                 push;
  logic                 pop;
  logic                 head_ftch;
  logic                 head_kill;

  logic                 ftch_rsp_vld_q;
  logic                 dmem_rsp_vld_q;
  logic [DATA_W-1:0]    ftch_rsp_data_q;
  logic [DATA_W-1:0]    dmem_rsp_data_q;
  logic                 err_q;

  // Full uses the registered count only; a pop this cycle frees a slot next cycle.
  assign full   = (cnt == CW'(MAX_OUTST));
  assign empty  = (cnt == '0);
  assign d_elig = bus.dmem_req_vld & (bus.dmem_req_we | !full);
  assign f_elig = bus.ftch_req_vld & !full;

  // Credit counts down the data grants left before fetch must win.
  assign pick_d = d_elig & !((credit == '0) & f_elig);
  assign pick_f = f_elig & !pick_d;

  assign bus.mem_req_vld   = pick_d | pick_f;
  assign bus.mem_req_we    = pick_d & bus.dmem_req_we;
  assign bus.mem_req_addr  = pick_d ? bus.dmem_req_addr : bus.ftch_req_addr;
  assign bus.mem_req_wdata = pick_d ? bus.dmem_req_wdata : '0;
  assign bus.mem_req_be    = pick_d ? bus.dmem_req_be : '0;
  assign bus.dmem_req_rdy  = pick_d & bus.mem_req_rdy;
  assign bus.ftch_req_rdy  = pick_f & bus.mem_req_rdy;

  assign xfer      = bus.mem_req_vld & bus.mem_req_rdy;
  assign push      = xfer & !bus.mem_req_we;
  assign pop       = bus.mem_rsp_vld & !empty;
  assign head_ftch = tag_ftch[rd_ptr];
  // A redirect in the same cycle also kills the fetch response popping now.
  assign head_kill = tag_kill[rd_ptr] | bus.ftch_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_ftch        <= '0;
      tag_kill        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      credit          <= SW'(STARVE_LIMIT);
      ftch_rsp_vld_q  <= 1'b0;
      dmem_rsp_vld_q  <= 1'b0;
      ftch_rsp_data_q <= '0;
      dmem_rsp_data_q <= '0;
      err_q           <= 1'b0;
    end else begin
      if (bus.ftch_flush)
        tag_kill <= tag_kill | tag_ftch;
      // Later assignment wins: the fetch pushed alongside a flush stays live.
      if (push) begin
        tag_ftch[wr_ptr] <= pick_f;
        tag_kill[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);

      if (!bus.ftch_req_vld || (xfer && pick_f))
        credit <= SW'(STARVE_LIMIT);
      else if (xfer && pick_d && (credit != '0))
        credit <= credit - SW'(1);

      ftch_rsp_vld_q <= pop & head_ftch & !head_kill;
      dmem_rsp_vld_q <= pop & !head_ftch;
      if (pop && head_ftch && !head_kill)
        ftch_rsp_data_q <= bus.mem_rsp_data;
      if (pop && !head_ftch)
        dmem_rsp_data_q <= bus.mem_rsp_data;
      if (bus.mem_rsp_vld && empty)
        err_q <= 1'b1;
    end
  end

  assign bus.ftch_rsp_vld  = ftch_rsp_vld_q;
  assign bus.ftch_rsp_data = ftch_rsp_data_q;
  assign bus.dmem_rsp_vld  = dmem_rsp_vld_q;
  assign bus.dmem_rsp_data = dmem_rsp_data_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: fetch streaming, starvation pattern, full FIFO,
// flush kill, orphan error and mid-operation reset.
module tb_mem_port_arb;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arb #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bench cycle: wait for the falling edge, apply inputs, let logic settle.
  task automatic drv(input int fv, input int fa, input int dv, input int dwe, input int da,
                     input int rv, input int rd, input int fl, input int rs);
    @(negedge clk);
    reset              = rs[0];
    bus.ftch_req_vld   = fv[0];
    bus.ftch_req_addr  = 32'(fa);
    bus.ftch_flush     = fl[0];
    bus.dmem_req_vld   = dv[0];
    bus.dmem_req_we    = dwe[0];
    bus.dmem_req_addr  = 32'(da);
    bus.dmem_req_wdata = 32'h1234_5678;
    bus.dmem_req_be    = 4'hF;
    bus.mem_req_rdy    = 1'b1;
    bus.mem_rsp_vld    = rv[0];
    bus.mem_rsp_data   = 32'(rd);
    #1;
  endtask

  initial begin
    logic exp_f;
    n_chk  = 0;
    n_fail = 0;
    reset              = 1'b1;
    bus.ftch_req_vld   = 1'b0;
    bus.ftch_req_addr  = '0;
    bus.ftch_flush     = 1'b0;
    bus.dmem_req_vld   = 1'b0;
    bus.dmem_req_we    = 1'b0;
    bus.dmem_req_addr  = '0;
    bus.dmem_req_wdata = '0;
    bus.dmem_req_be    = '0;
    bus.mem_req_rdy    = 1'b1;
    bus.mem_rsp_vld    = 1'b0;
    bus.mem_rsp_data   = '0;

    // reset values
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("rst_ftch_rsp_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("rst_dmem_rsp_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    chk_eq("rst_ftch_rsp_data", 64'(bus.ftch_rsp_data), 64'd0);
    chk_eq("rst_dmem_rsp_data", 64'(bus.dmem_rsp_data), 64'd0);
    chk_eq("rst_err", 64'(bus.err), 64'd0);
    chk_eq("idle_mem_req_vld", 64'(bus.mem_req_vld), 64'd0);
    chk_eq("idle_ftch_rdy", 64'(bus.ftch_req_rdy), 64'd0);
    chk_eq("idle_dmem_rdy", 64'(bus.dmem_req_rdy), 64'd0);

    // back-to-back fetch reads, responses two cycles later
    drv(1, 'h0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("f0_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    chk_eq("f0_addr", 64'(bus.mem_req_addr), 64'h0);
    chk_eq("f0_we", 64'(bus.mem_req_we), 64'd0);
    chk_eq("f0_dmem_rdy", 64'(bus.dmem_req_rdy), 64'd0);
    drv(1, 'h4, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("f1_addr", 64'(bus.mem_req_addr), 64'h4);
    chk_eq("f1_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    drv(1, 'h8, 0, 0, 0, 1, 'hA0, 0, 0);
    chk_eq("f2_addr", 64'(bus.mem_req_addr), 64'h8);
    drv(0, 0, 0, 0, 0, 1, 'hA4, 0, 0);
    chk_eq("r0_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("r0_data", 64'(bus.ftch_rsp_data), 64'hA0);
    chk_eq("r0_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 1, 'hA8, 0, 0);
    chk_eq("r1_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("r1_data", 64'(bus.ftch_rsp_data), 64'hA4);
    chk_eq("r1_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("r2_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("r2_data", 64'(bus.ftch_rsp_data), 64'hA8);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("r_end_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("r_end_data_held", 64'(bus.ftch_rsp_data), 64'hA8);

    // both valid: D,D,D,D,F repeating (data side issues writes)
    for (int k = 0; k < 12; k++) begin
      exp_f = ((k % 5) == 4);
      drv(1, 'h1000, 1, 1, 'h2000, 0, 0, 0, 0);
      chk_eq("starve_ftch_rdy", 64'(bus.ftch_req_rdy), 64'(exp_f));
      chk_eq("starve_dmem_rdy", 64'(bus.dmem_req_rdy), 64'(!exp_f));
    end
    // fetch drops: streak clears, so four data grants precede the next fetch
    drv(0, 0, 1, 1, 'h2000, 0, 0, 0, 0);
    chk_eq("drop_dmem_rdy", 64'(bus.dmem_req_rdy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      exp_f = (k == 4);
      drv(1, 'h1000, 1, 1, 'h2000, 0, 0, 0, 0);
      chk_eq("clr_ftch_rdy", 64'(bus.ftch_req_rdy), 64'(exp_f));
      chk_eq("clr_dmem_rdy", 64'(bus.dmem_req_rdy), 64'(!exp_f));
    end
    for (int k = 0; k < 2; k++) begin
      drv(1, 'h1000, 1, 1, 'h2000, 0, 0, 0, 0);
      chk_eq("pre_rst_dmem_rdy", 64'(bus.dmem_req_rdy), 64'd1);
    end

    // reset with three fetch reads outstanding and streak at 2
    drv(0, 0, 0, 0, 0, 1, 'h55, 0, 1);
    for (int k = 0; k < 5; k++) begin
      exp_f = (k == 4);
      drv(1, 'h400, 1, 1, 'h2000, 0, 0, 0, 0);
      if (k == 0) begin
        chk_eq("postrst_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
        chk_eq("postrst_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
      end
      chk_eq("postrst_ftch_rdy", 64'(bus.ftch_req_rdy), 64'(exp_f));
      chk_eq("postrst_dmem_rdy", 64'(bus.dmem_req_rdy), 64'(!exp_f));
    end
    drv(0, 0, 0, 0, 0, 1, 'h77, 0, 0);
    // FIFO now empty: this response is an orphan
    drv(0, 0, 0, 0, 0, 1, 'h99, 0, 0);
    chk_eq("live_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("live_data", 64'(bus.ftch_rsp_data), 64'h77);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("orphan_err", 64'(bus.err), 64'd1);
    chk_eq("orphan_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("orphan_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("err_sticky", 64'(bus.err), 64'd1);

    // full FIFO blocks reads but not writes; freed slot visible next cycle
    for (int i = 0; i < 4; i++) begin
      drv(1, 'h300 + 4 * i, 0, 0, 0, 0, 0, 0, 0);
      chk_eq("fill_ftch_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    end
    drv(1, 'h310, 1, 0, 'h600, 0, 0, 0, 0);
    chk_eq("full_ftch_rdy", 64'(bus.ftch_req_rdy), 64'd0);
    chk_eq("full_dmem_rd_rdy", 64'(bus.dmem_req_rdy), 64'd0);
    chk_eq("full_mem_vld", 64'(bus.mem_req_vld), 64'd0);
    drv(1, 'h310, 1, 1, 'h604, 0, 0, 0, 0);
    chk_eq("full_wr_rdy", 64'(bus.dmem_req_rdy), 64'd1);
    chk_eq("full_wr_ftch_rdy", 64'(bus.ftch_req_rdy), 64'd0);
    chk_eq("full_wr_we", 64'(bus.mem_req_we), 64'd1);
    drv(1, 'h310, 0, 0, 0, 1, 'hC0, 0, 0);
    chk_eq("pop_same_cyc_rdy", 64'(bus.ftch_req_rdy), 64'd0);
    drv(1, 'h310, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("pop_next_cyc_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    chk_eq("pop_rsp_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("pop_rsp_data", 64'(bus.ftch_rsp_data), 64'hC0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("rst_clears_err", 64'(bus.err), 64'd0);
    chk_eq("rst_clears_vld", 64'(bus.ftch_rsp_vld), 64'd0);

    // two fetches and one data read outstanding, then flush with new fetch 0x100
    drv(1, 'h40, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("fl_f0_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    drv(0, 0, 1, 0, 'h200, 0, 0, 0, 0);
    chk_eq("fl_d_rdy", 64'(bus.dmem_req_rdy), 64'd1);
    chk_eq("fl_d_we", 64'(bus.mem_req_we), 64'd0);
    drv(1, 'h44, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("fl_f1_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    drv(1, 'h100, 0, 0, 0, 0, 0, 1, 0);
    chk_eq("fl_new_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    chk_eq("fl_new_addr", 64'(bus.mem_req_addr), 64'h100);
    drv(0, 0, 0, 0, 0, 1, 'hBAD0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 'hD00D, 0, 0);
    chk_eq("kill0_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("kill0_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 1, 'hBAD4, 0, 0);
    chk_eq("fl_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd1);
    chk_eq("fl_dmem_data", 64'(bus.dmem_rsp_data), 64'hD00D);
    chk_eq("fl_dmem_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 1, 'h1000, 0, 0);
    chk_eq("kill1_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("kill1_dmem_vld", 64'(bus.dmem_rsp_vld), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("fl_new_vld", 64'(bus.ftch_rsp_vld), 64'd1);
    chk_eq("fl_new_data", 64'(bus.ftch_rsp_data), 64'h1000);

    // flush in the same cycle a fetch response pops: dropped
    drv(1, 'h200, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("sp_rdy", 64'(bus.ftch_req_rdy), 64'd1);
    drv(0, 0, 0, 0, 0, 1, 'hEE, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("sp_ftch_vld", 64'(bus.ftch_rsp_vld), 64'd0);
    chk_eq("sp_data_held", 64'(bus.ftch_rsp_data), 64'h1000);
    chk_eq("sp_err", 64'(bus.err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter that shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the MIPS pipeline. It picks one requester per cycle with data-side priority and a fetch anti-starvation limit, and tracks outstanding reads in an in-order tag FIFO. It routes each memory response back to its requester. It also discards in-flight fetch responses when the memory stage redirects fetch (branch/jump resolve).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTST, 4, maximum outstanding reads (tag FIFO depth, power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  in  1  clock; everything samples on its rising edge
- reset  in  1  synchronous, active-high reset
- ftch_req_vld  in  1  fetch read request
- ftch_req_addr  in  ADDR_W  fetch address
- ftch_req_rdy  out  1  fetch request accepted this cycle
- ftch_flush  in  1  redirect from memory stage; kill all fetch reads already outstanding
- ftch_rsp_vld  out  1  fetch read data valid (one-cycle pulse)
- ftch_rsp_data  out  DATA_W  fetch read data
- dmem_req_vld  in  1  data request
- dmem_req_we  in  1  1 = write, 0 = read
- dmem_req_addr  in  ADDR_W  data address
- dmem_req_wdata  in  DATA_W  write data
- dmem_req_be  in  DATA_W/8  byte enables (writes)
- dmem_req_rdy  out  1  data request accepted this cycle
- dmem_rsp_vld  out  1  data read data valid (one-cycle pulse)
- dmem_rsp_data  out  DATA_W  data read data
- mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  request to memory
- mem_req_rdy  in  1  memory accepts request
- mem_rsp_vld  in  1  memory read response, strictly in request order
- mem_rsp_data  in  DATA_W  memory read data
- err  out  1  sticky: response arrived with no outstanding read

## Operation
- Eligibility:
  - Reads are eligible only if the tag FIFO is not full. Full is computed from the registered count, with no same-cycle pop bypass.
  - Writes are always eligible and push no tag.
- Arbitration, combinational in the request cycle:
  - Data is chosen if eligible, unless streak == STARVE_LIMIT and fetch is eligible.
  - Otherwise fetch is chosen if eligible.
- mem_req_* are driven by the chosen requester's fields; mem_req_we = 0 for fetch. mem_req_vld = 1 whenever either requester is chosen.
- The chosen requester's rdy = mem_req_rdy; the other requester's rdy = 0. A transfer occurs when vld & rdy.
- Starvation counter streak (0..STARVE_LIMIT):
  - Increments on a data transfer while ftch_req_vld = 1.
  - Clears on a fetch transfer or whenever ftch_req_vld = 0.
- Tag FIFO entry = {is_ftch, killed}.
  - A read transfer pushes {src, 0}.
  - mem_rsp_vld pops the head entry.
- ftch_flush sets killed on every valid is_ftch entry present at that edge.
  - A fetch read transferred in the same cycle is pushed with killed = 0, so it is the post-redirect fetch.
  - A fetch response popping in the same cycle is dropped.
- Pop routing:
  - is_ftch & !killed → ftch_rsp.
  - !is_ftch → dmem_rsp.
  - killed → discarded, no pulse.
- mem_rsp_vld with an empty FIFO sets err. It pops nothing and produces no response.
- Simultaneous push and pop: both happen, and the count is unchanged.

## Timing
- Request path is combinational: 0-cycle grant.
- Response path is registered: ftch_rsp_vld / dmem_rsp_vld and data assert 1 cycle after mem_rsp_vld, for exactly 1 cycle. Data is held until the next response.
- Reset values: ftch_rsp_vld = 0, dmem_rsp_vld = 0, ftch_rsp_data = 0, dmem_rsp_data = 0, err = 0, FIFO empty, streak = 0.
- With no requests after reset, mem_req_vld = 0 and both rdy = 0.
- Reset mid-operation clears all outstanding tags. Memory must be reset alongside; any later orphan response sets err.
- The pointers wrap modulo MAX_OUTST.
- Responses carry no backpressure; requesters must always accept.

## Test plan
- Back-to-back fetch reads to 0x00, 0x04, 0x08 with mem_req_rdy = 1 and responses 2 cycles later carrying 0xA0, 0xA4, 0xA8 → ftch_rsp_vld pulses in order with those data, dmem_rsp_vld never asserts.
- Both requesters valid continuously, STARVE_LIMIT = 4 → grant pattern D,D,D,D,F repeating. After ftch_req_vld drops, streak returns to 0.
- Four fetch reads outstanding (MAX_OUTST = 4) → ftch_req_rdy = 0 and dmem read blocked. A dmem write is still granted. One response frees a slot on the next cycle, not the same cycle.
- Two fetch reads and one data read outstanding, then ftch_flush with a new fetch to 0x100 in the same cycle → the two old fetch responses are dropped and the dmem response is delivered. The 0x100 response appears on ftch_rsp.
- mem_rsp_vld with FIFO empty → err = 1 and stays set, no rsp pulse. Reset → err = 0.
- Reset asserted with three reads outstanding → FIFO empty, all rsp_vld = 0 on the next cycle, arbitration restarts with streak = 0.
